// File: rtl/pcie_to_ctrl_mc.sv
// Power-management turn-off handshake: tracks outstanding completions per channel
// and acknowledges PME_Turn_Off once they drain or a drain timeout expires.
module pcie_to_ctrl_mc #(
    parameter int G_CH_COUNT   = 4,
    parameter int G_PEND_W     = 4,
    parameter int G_TMO_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [G_CH_COUNT-1:0] req_compl_i,
    input  logic [G_CH_COUNT-1:0] compl_done_i,
    input  logic                  cfg_to_turnoff_n_i,
    output logic                  cfg_turnoff_ok_n_o,
    output logic                  req_block_o,
    output logic                  pend_any_o,
    output logic [G_CH_COUNT-1:0] pend_ovf_o,
    output logic                  tmo_o,
    output logic [1:0]            state_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DRAIN = 2'b01,
        ST_ACK   = 2'b10
    } state_t;

    localparam int TMO_W = (G_TMO_CYCLES > 1) ? $clog2(G_TMO_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST =
        (G_TMO_CYCLES > 0) ? TMO_W'(G_TMO_CYCLES - 1) : '0;
    localparam logic [G_PEND_W-1:0] CNT_MAX = '1;

    state_t                state_q, state_d;
    logic [TMO_W-1:0]      tmo_cnt_q;
    logic                  tmo_q;
    logic                  tmo_hit;
    logic                  set_tmo;
    logic [G_PEND_W-1:0]   cnt_q [G_CH_COUNT];
    logic [G_CH_COUNT-1:0] ovf_q;

    // NOTE: the counter array is reset explicitly; pending state must read zero after rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < G_CH_COUNT; i++) cnt_q[i] <= '0;
            ovf_q <= '0;
        end else begin
            for (int i = 0; i < G_CH_COUNT; i++) begin
                if (req_compl_i[i] && !compl_done_i[i]) begin
                    if (cnt_q[i] == CNT_MAX) ovf_q[i] <= 1'b1;
                    else                     cnt_q[i] <= cnt_q[i] + G_PEND_W'(1);
                end else if (!req_compl_i[i] && compl_done_i[i] && cnt_q[i] != '0) begin
                    cnt_q[i] <= cnt_q[i] - G_PEND_W'(1);
                end
            end
        end
    end

    always_comb begin
        pend_any_o = 1'b0;
        for (int i = 0; i < G_CH_COUNT; i++) pend_any_o = pend_any_o | (cnt_q[i] != '0);
    end

    assign tmo_hit = (G_TMO_CYCLES != 0) && (tmo_cnt_q == TMO_LAST);

    // Release of turn-off beats drain completion, which beats timeout.
    always_comb begin
        state_d = state_q;
        set_tmo = 1'b0;
        case (state_q)
            ST_IDLE:  if (!cfg_to_turnoff_n_i) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (cfg_to_turnoff_n_i) state_d = ST_IDLE;
                else if (!pend_any_o)   state_d = ST_ACK;
                else if (tmo_hit) begin
                    state_d = ST_ACK;
                    set_tmo = 1'b1;
                end
            end
            ST_ACK:   if (cfg_to_turnoff_n_i) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_cnt_q <= (state_q == ST_DRAIN) ? tmo_cnt_q + TMO_W'(1) : '0;
            if (set_tmo) tmo_q <= 1'b1;
        end
    end

    assign cfg_turnoff_ok_n_o = (state_q != ST_ACK);
    assign req_block_o        = (state_q == ST_DRAIN) || (state_q == ST_ACK);
    assign pend_ovf_o         = ovf_q;
    assign tmo_o              = tmo_q;
    assign state_o            = state_q;

endmodule

// File: tb/tb_pcie_to_ctrl_mc.sv
// Directed scoreboard bench for pcie_to_ctrl_mc (4 channels, 2-bit counters, 8-cycle timeout).
// An 'x' bit in an expected value marks a bit that is not checked at that step.
module tb_pcie_to_ctrl_mc;

    localparam int CH  = 4;
    localparam int PW  = 2;
    localparam int TMO = 8;

    localparam logic [1:0] I = 2'b00;
    localparam logic [1:0] D = 2'b01;
    localparam logic [1:0] A = 2'b10;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] req_compl_i;
    logic [CH-1:0] compl_done_i;
    logic          cfg_to_turnoff_n_i;
    logic          cfg_turnoff_ok_n_o;
    logic          req_block_o;
    logic          pend_any_o;
    logic [CH-1:0] pend_ovf_o;
    logic          tmo_o;
    logic [1:0]    state_o;

    pcie_to_ctrl_mc #(
        .G_CH_COUNT  (CH),
        .G_PEND_W    (PW),
        .G_TMO_CYCLES(TMO)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .req_compl_i       (req_compl_i),
        .compl_done_i      (compl_done_i),
        .cfg_to_turnoff_n_i(cfg_to_turnoff_n_i),
        .cfg_turnoff_ok_n_o(cfg_turnoff_ok_n_o),
        .req_block_o       (req_block_o),
        .pend_any_o        (pend_any_o),
        .pend_ovf_o        (pend_ovf_o),
        .tmo_o             (tmo_o),
        .state_o           (state_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]    st;
        logic          ok_n;
        logic          blk;
        logic          any;
        logic [CH-1:0] ovf;
        logic          tmo;
    } obs_t;

    typedef struct {
        string tag;
        obs_t  exp;
    } sb_t;

    sb_t sb[$];
    int  n_vec = 0;
    int  n_err = 0;

    // Handshake outputs follow directly from the state encoding.
    function automatic obs_t mk(logic [1:0] st, logic any, logic [CH-1:0] ovf, logic tmo);
        obs_t r;
        r.st   = st;
        r.ok_n = (st != A);
        r.blk  = (st == D) || (st == A);
        r.any  = any;
        r.ovf  = ovf;
        r.tmo  = tmo;
        return r;
    endfunction

    task automatic step(input string tag, input logic r, input logic [CH-1:0] rq,
                        input logic [CH-1:0] dn, input logic to_n, input obs_t e);
        sb_t  item;
        sb_t  got;
        obs_t o;
        rst                = r;
        req_compl_i        = rq;
        compl_done_i       = dn;
        cfg_to_turnoff_n_i = to_n;
        item.tag = tag;
        item.exp = e;
        sb.push_back(item);
        @(posedge clk);
        #1;
        got    = sb.pop_front();
        o.st   = state_o;
        o.ok_n = cfg_turnoff_ok_n_o;
        o.blk  = req_block_o;
        o.any  = pend_any_o;
        o.ovf  = pend_ovf_o;
        o.tmo  = tmo_o;
        for (int i = 0; i < $bits(obs_t); i++)
            if (got.exp[i] === 1'bx) o[i] = 1'bx;
        n_vec++;
        assert (o === got.exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b (st,ok_n,blk,any,ovf,tmo)", got.tag, o, got.exp);
        end
    endtask

    initial begin
        // Reset
        step("rst0", 1, 4'h0, 4'h0, 1, mk(I, 0, 4'b0000, 0));
        step("rst1", 1, 4'h0, 4'h0, 1, mk(I, 0, 4'b0000, 0));

        // Fastest acknowledge with nothing pending, then release
        step("a_drain", 0, 4'h0, 4'h0, 0, mk(D, 0, 4'b0000, 0));
        step("a_ack",   0, 4'h0, 4'h0, 0, mk(A, 0, 4'b0000, 0));
        step("a_hold",  0, 4'h0, 4'h0, 0, mk(A, 0, 4'b0000, 0));
        step("a_rel",   0, 4'h0, 4'h0, 1, mk(I, 0, 4'b0000, 0));
        step("a_idle",  0, 4'h0, 4'h0, 1, mk(I, 0, 4'b0000, 0));

        // Underflow on done-only pulses is ignored
        step("uflow",   0, 4'h0, 4'hF, 1, mk(I, 0, 4'b0000, 0));

        // Three requests on ch1, drain while three completions return
        step("b_req1",  0, 4'h2, 4'h0, 1, mk(I, 1, 4'b0000, 0));
        step("b_req2",  0, 4'h2, 4'h0, 1, mk(I, 1, 4'b0000, 0));
        step("b_req3",  0, 4'h2, 4'h0, 1, mk(I, 1, 4'b00x0, 0));
        step("b_drain", 0, 4'h0, 4'h0, 0, mk(D, 1, 4'b00x0, 0));
        step("b_done1", 0, 4'h0, 4'h2, 0, mk(D, 1, 4'b00x0, 0));
        step("b_done2", 0, 4'h0, 4'h2, 0, mk(D, 1, 4'b00x0, 0));
        step("b_done3", 0, 4'h0, 4'h2, 0, mk(D, 0, 4'b00x0, 0));
        step("b_ack",   0, 4'h0, 4'h0, 0, mk(A, 0, 4'b00x0, 0));
        step("b_rel",   0, 4'h0, 4'h0, 1, mk(I, 0, 4'b00x0, 0));

        // Simultaneous req+done on ch0 leaves the count at 1; release during DRAIN
        step("c_req",   0, 4'h1, 4'h0, 1, mk(I, 1, 4'b00x0, 0));
        step("c_both",  0, 4'h1, 4'h1, 1, mk(I, 1, 4'b00x0, 0));
        step("c_drain", 0, 4'h0, 4'h0, 0, mk(D, 1, 4'b00x0, 0));
        step("c_both2", 0, 4'h1, 4'h1, 0, mk(D, 1, 4'b00x0, 0));
        step("c_both3", 0, 4'h1, 4'h1, 0, mk(D, 1, 4'b00x0, 0));
        step("c_rel",   0, 4'h0, 4'h0, 1, mk(I, 1, 4'b00x0, 0));
        step("c_done",  0, 4'h0, 4'h1, 1, mk(I, 0, 4'b00x0, 0));

        // ch2 stays pending: ACK forced after exactly 8 DRAIN cycles
        step("d_req",   0, 4'h4, 4'h0, 1, mk(I, 1, 4'b00x0, 0));
        step("d_drain", 0, 4'h0, 4'h0, 0, mk(D, 1, 4'b00x0, 0));
        for (int k = 0; k < TMO - 2; k++)
            step($sformatf("d_wait%0d", k), 0, 4'h0, 4'h0, 0, mk(D, 1, 4'b00x0, 0));
        step("d_last",  0, 4'h0, 4'h0, 0, mk(D, 1, 4'b00x0, 0));
        step("d_tmo",   0, 4'h0, 4'h0, 0, mk(A, 1, 4'b00x0, 1));
        step("d_hold",  0, 4'h0, 4'h0, 0, mk(A, 1, 4'b00x0, 1));
        step("d_rel",   0, 4'h0, 4'h0, 1, mk(I, 1, 4'b00x0, 1));
        step("d_stick", 0, 4'h0, 4'h0, 1, mk(I, 1, 4'b00x0, 1));
        step("d_clr",   0, 4'h0, 4'h4, 1, mk(I, 0, 4'b00x0, 1));

        // Saturation on ch3 with 2-bit counters
        step("e_req1",  0, 4'h8, 4'h0, 1, mk(I, 1, 4'b00x0, 1));
        step("e_req2",  0, 4'h8, 4'h0, 1, mk(I, 1, 4'b00x0, 1));
        step("e_req3",  0, 4'h8, 4'h0, 1, mk(I, 1, 4'bx0x0, 1));
        step("e_req4",  0, 4'h8, 4'h0, 1, mk(I, 1, 4'b10x0, 1));
        step("e_done1", 0, 4'h0, 4'h8, 1, mk(I, 1, 4'b10x0, 1));
        step("e_done2", 0, 4'h0, 4'h8, 1, mk(I, 1, 4'b10x0, 1));
        step("e_done3", 0, 4'h0, 4'h8, 1, mk(I, 0, 4'b10x0, 1));
        step("e_idle",  0, 4'h0, 4'h0, 1, mk(I, 0, 4'b10x0, 1));

        // Reset while in ACK, with other inputs active
        step("f_drain", 0, 4'h0, 4'h0, 0, mk(D, 0, 4'b10x0, 1));
        step("f_ack",   0, 4'h0, 4'h0, 0, mk(A, 0, 4'b10x0, 1));
        step("f_rst",   1, 4'hF, 4'h0, 0, mk(I, 0, 4'b0000, 0));
        step("f_after", 0, 4'h0, 4'h0, 1, mk(I, 0, 4'b0000, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
